alu_tr_vote: RTL and testbench

ALU_TR_VOTE -- requirements
Module: alu_tr_vote

---
 rtl/alu_tr_vote.sv | 235 +++++++++++++++++++++++
 tb/tb_alu_tr_vote.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_tr_vote.sv
// Time-redundant ALU: every operation is executed repeatedly on held operands and the
// results are voted (2-of-2, then 2-of-3), retrying whole rounds until agreement or give-up.
module alu_tr_vote #(
    parameter int WIDTH      = 32,
    parameter int MAX_ROUNDS = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUControl,
    input  logic             inj_en,
    input  logic [WIDTH-1:0] inj_mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Carry,
    output logic             OverFlow,
    output logic             Negative,
    output logic             fault_detected_out,
    output logic             uncorrectable,
    output logic [CNT_W-1:0] fault_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);
    localparam int WW  = WIDTH + 2;
    localparam int RW  = $clog2(MAX_ROUNDS + 1);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EXEC1 = 3'd1,
        S_EXEC2 = 3'd2,
        S_EXEC3 = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;
    logic [WW-1:0]    r1_q, r1_d;
    logic [WW-1:0]    r2_q, r2_d;
    logic [RW-1:0]    round_q, round_d;
    logic             mism_q, mism_d;
    logic [WIDTH-1:0] res_q;
    logic             c_q, v_q, z_q, n_q, fd_q, unc_q;

    logic             accept;
    logic             done_load;
    logic [WW-1:0]    done_word;
    logic             done_fd;
    logic             done_unc;

    // ALU datapath on the held operands
    logic [WIDTH:0]   add_ext, sub_ext;
    logic             slt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;
    logic [WW-1:0]    word;
    logic             match_r1, match_r2;
    logic [RW:0]      round_inc;
    logic             last_round;

    assign add_ext = {1'b0, a_q} + {1'b0, b_q};
    assign sub_ext = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);
    assign slt     = $signed(a_q) < $signed(b_q);

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_q)
            3'b000: begin
                alu_res = add_ext[MSB:0];
                alu_c   = add_ext[WIDTH];
                alu_v   = (a_q[MSB] == b_q[MSB]) && (add_ext[MSB] != a_q[MSB]);
            end
            3'b001: begin
                // carry out of A + ~B + 1 is set exactly when A >= B unsigned
                alu_res = sub_ext[MSB:0];
                alu_c   = sub_ext[WIDTH];
                alu_v   = (a_q[MSB] != b_q[MSB]) && (sub_ext[MSB] != a_q[MSB]);
            end
            3'b010:  alu_res = a_q & b_q;
            3'b011:  alu_res = a_q | b_q;
            3'b100:  alu_res = a_q ^ b_q;
            3'b101:  alu_res = {{(WIDTH-1){1'b0}}, slt};
            default: alu_res = '0;
        endcase
    end

    // Injected faults corrupt only the result field of the compared word
    assign word       = {alu_c, alu_v, alu_res ^ (inj_en ? inj_mask : '0)};
    assign match_r1   = (word == r1_q);
    assign match_r2   = (word == r2_q);
    assign round_inc  = {1'b0, round_q} + (RW+1)'(1);
    assign last_round = (round_inc >= (RW+1)'(MAX_ROUNDS));
    assign accept     = (state_q == S_IDLE) && in_valid;

    always_comb begin
        state_d   = state_q;
        r1_d      = r1_q;
        r2_d      = r2_q;
        round_d   = round_q;
        mism_d    = mism_q;
        done_load = 1'b0;
        done_word = '0;
        done_fd   = 1'b0;
        done_unc  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_EXEC1;
                    round_d = '0;
                    mism_d  = 1'b0;
                end
            end
            S_EXEC1: begin
                r1_d    = word;
                state_d = S_EXEC2;
            end
            S_EXEC2: begin
                r2_d = word;
                if (match_r1) begin
                    // agreement after a failed round still counts as a corrected fault
                    state_d   = S_DONE;
                    done_load = 1'b1;
                    done_word = r1_q;
                    done_fd   = mism_q;
                end else begin
                    state_d = S_EXEC3;
                    mism_d  = 1'b1;
                end
            end
            S_EXEC3: begin
                if (match_r1 || match_r2) begin
                    state_d   = S_DONE;
                    done_load = 1'b1;
                    done_word = match_r1 ? r1_q : r2_q;
                    done_fd   = 1'b1;
                end else begin
                    round_d = round_inc[RW-1:0];
                    if (last_round) begin
                        state_d   = S_DONE;
                        done_load = 1'b1;
                        done_unc  = 1'b1;
                    end else begin
                        state_d = S_EXEC1;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            r1_q    <= '0;
            r2_q    <= '0;
            round_q <= '0;
            mism_q  <= 1'b0;
            res_q   <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            fd_q    <= 1'b0;
            unc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            round_q <= round_d;
            mism_q  <= mism_d;
            if (accept) begin
                a_q   <= A;
                b_q   <= B;
                op_q  <= ALUControl;
                fd_q  <= 1'b0;
                unc_q <= 1'b0;
            end
            if (done_load) begin
                res_q <= done_word[MSB:0];
                v_q   <= done_word[WIDTH];
                c_q   <= done_word[WIDTH+1];
                z_q   <= !done_unc && (done_word[MSB:0] == '0);
                n_q   <= done_word[MSB];
                fd_q  <= done_fd;
                unc_q <= done_unc;
            end
        end
    end

    // Saturating event counters: index 0 counts corrected faults, index 1 give-ups
    logic [1:0] cnt_inc;
    assign cnt_inc = {done_load & done_unc, done_load & done_fd};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= '0;
                end else if (cnt_inc[gi] && (cnt_q != '1)) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign in_ready           = (state_q == S_IDLE);
    assign out_valid          = (state_q == S_DONE);
    assign Result             = res_q;
    assign Zero               = z_q;
    assign Carry              = c_q;
    assign OverFlow           = v_q;
    assign Negative           = n_q;
    assign fault_detected_out = fd_q;
    assign uncorrectable      = unc_q;
    assign fault_cnt          = g_cnt[0].cnt_q;
    assign uncorr_cnt         = g_cnt[1].cnt_q;

endmodule

// File: tb/tb_alu_tr_vote.sv
// Randomized bench for alu_tr_vote: per-EXEC-cycle fault masks are scripted and the
// expected vote outcome, flags, latency and counters come from an arithmetic model.
module tb_alu_tr_vote;
    localparam int W    = 32;
    localparam int MAXR = 2;
    localparam int NM   = 3 * MAXR;
    localparam longint SMAX = 64'sh0000_0000_7FFF_FFFF;
    localparam longint SMIN = -64'sh0000_0000_8000_0000;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, inj_en, out_valid, out_ready;
    logic [W-1:0] A, B, inj_mask, Result;
    logic [2:0]   ALUControl;
    logic         Zero, Carry, OverFlow, Negative, fault_detected_out, uncorrectable;
    logic [15:0]  fault_cnt, uncorr_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int m_fault  = 0;
    int m_uncorr = 0;
    int txn_no   = 0;
    logic [W-1:0] masks [NM];

    always #5 clk = ~clk;

    alu_tr_vote #(.WIDTH(W), .MAX_ROUNDS(MAXR), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .ALUControl(ALUControl), .inj_en(inj_en), .inj_mask(inj_mask),
        .out_valid(out_valid), .out_ready(out_ready), .Result(Result), .Zero(Zero),
        .Carry(Carry), .OverFlow(OverFlow), .Negative(Negative),
        .fault_detected_out(fault_detected_out), .uncorrectable(uncorrectable),
        .fault_cnt(fault_cnt), .uncorr_cnt(uncorr_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_masks();
        for (int i = 0; i < NM; i++) masks[i] = '0;
    endtask

    // Golden ALU from plain integer arithmetic, then the voting rules replayed over the mask script
    task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] res, output logic c, output logic v,
                         output logic fd, output logic unc, output int lat);
        longint sa, sb, s, full;
        logic [W-1:0] g, w1, w2, w3;
        logic gc, gv;
        int k;
        bit done, mism;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        g = '0; gc = 1'b0; gv = 1'b0;
        case (op)
            3'd0: begin
                full = longint'(a) + longint'(b);
                g  = full[W-1:0];
                gc = full >= 64'sh1_0000_0000;
                s  = sa + sb;
                gv = (s > SMAX) || (s < SMIN);
            end
            3'd1: begin
                g  = a - b;
                gc = (a >= b);
                s  = sa - sb;
                gv = (s > SMAX) || (s < SMIN);
            end
            3'd2: g = a & b;
            3'd3: g = a | b;
            3'd4: g = a ^ b;
            3'd5: g = (sa < sb) ? 1 : 0;
            default: g = '0;
        endcase
        k = 0; done = 0; mism = 0; res = '0; fd = 0; unc = 0;
        for (int r = 0; r < MAXR && !done; r++) begin
            w1 = g ^ masks[k];
            w2 = g ^ masks[k+1];
            k += 2;
            if (w1 == w2) begin
                res = w1; fd = mism; done = 1;
            end else begin
                w3 = g ^ masks[k];
                k++;
                if (w3 == w1 || w3 == w2) begin
                    res = w3; fd = 1; done = 1;
                end else begin
                    mism = 1;
                end
            end
        end
        if (!done) begin
            unc = 1; res = '0;
        end
        c   = unc ? 1'b0 : gc;
        v   = unc ? 1'b0 : gv;
        lat = k + 1;
    endtask

    task automatic drive_inj(input int idx);
        if (idx < NM && masks[idx] != '0) begin
            inj_en   = 1'b1;
            inj_mask = masks[idx];
        end else begin
            inj_en   = 1'b0;
            inj_mask = $urandom;
        end
    endtask

    task automatic run_txn(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input int hold);
        logic [W-1:0] e_res;
        logic e_c, e_v, e_fd, e_unc;
        int e_lat, edges;
        model(op, a, b, e_res, e_c, e_v, e_fd, e_unc, e_lat);
        @(negedge clk);
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        A = a; B = b; ALUControl = op; in_valid = 1'b1;
        @(posedge clk); #1;
        // scramble inputs while busy: operands must stay latched and in_valid ignored
        A = $urandom; B = $urandom; ALUControl = 3'($urandom);
        in_valid = 1'($urandom_range(0, 1));
        edges = 0;
        drive_inj(0);
        while (edges < 40) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk); #1;
            edges++;
            drive_inj(edges);
            in_valid = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        inj_en = 1'b1; inj_mask = $urandom;
        if (e_fd)  m_fault++;
        if (e_unc) m_uncorr++;
        check({tag, ".out_valid"}, 64'(out_valid), 64'd1);
        check({tag, ".latency"}, 64'(edges + 1), 64'(e_lat));
        check({tag, ".Result"}, 64'(Result), 64'(e_res));
        check({tag, ".Carry"}, 64'(Carry), 64'(e_c));
        check({tag, ".OverFlow"}, 64'(OverFlow), 64'(e_v));
        check({tag, ".Zero"}, 64'(Zero), 64'(!e_unc && e_res == '0));
        check({tag, ".Negative"}, 64'(Negative), 64'(e_res[W-1]));
        check({tag, ".fault_detected"}, 64'(fault_detected_out), 64'(e_fd));
        check({tag, ".uncorrectable"}, 64'(uncorrectable), 64'(e_unc));
        check({tag, ".fault_cnt"}, 64'(fault_cnt), 64'(m_fault));
        check({tag, ".uncorr_cnt"}, 64'(uncorr_cnt), 64'(m_uncorr));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); @(negedge clk);
            check({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, ".hold_result"}, 64'(Result), 64'(e_res));
            check({tag, ".hold_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        inj_en = 1'b0;
        @(negedge clk);
        check({tag, ".post_valid"}, 64'(out_valid), 64'd0);
        check({tag, ".post_ready"}, 64'(in_ready), 64'd1);
        txn_no++;
        $display("txn %0d %s op=%0d A=%h B=%h -> Result=%h C=%0d V=%0d fd=%0d unc=%0d lat=%0d",
                 txn_no, tag, op, a, b, Result, Carry, OverFlow, fault_detected_out,
                 uncorrectable, edges + 1);
    endtask

    task automatic reset_mid_txn();
        clear_masks();
        masks[1] = 32'hFFFF_FFFF;
        @(negedge clk);
        A = 32'hF5; B = 32'hAA; ALUControl = 3'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int e = 0; e < 2; e++) begin
            drive_inj(e);
            @(posedge clk); #1;
        end
        drive_inj(2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        inj_en = 1'b0;
        m_fault = 0;
        m_uncorr = 0;
        @(negedge clk);
        check("rst_mid.out_valid", 64'(out_valid), 64'd0);
        check("rst_mid.in_ready", 64'(in_ready), 64'd1);
        check("rst_mid.fault_cnt", 64'(fault_cnt), 64'd0);
        check("rst_mid.uncorr_cnt", 64'(uncorr_cnt), 64'd0);
        check("rst_mid.Result", 64'(Result), 64'd0);
        check("rst_mid.fault_detected", 64'(fault_detected_out), 64'd0);
        @(posedge clk); @(negedge clk);
        check("rst_mid.no_emit", 64'(out_valid), 64'd0);
        txn_no++;
        $display("txn %0d rst_mid aborted in EXEC3", txn_no);
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] pool [5];
        pool[0] = '0; pool[1] = '1; pool[2] = 32'h8000_0000; pool[3] = 32'h7FFF_FFFF; pool[4] = 32'h5;
        if ($urandom_range(0, 2) == 0) return pool[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; inj_en = 1'b0;
        inj_mask = '0; A = '0; B = '0; ALUControl = '0;
        clear_masks();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset.in_ready", 64'(in_ready), 64'd1);
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.Result", 64'(Result), 64'd0);
        check("reset.flags", 64'({Zero, Carry, OverFlow, Negative}), 64'd0);
        check("reset.status", 64'({fault_detected_out, uncorrectable}), 64'd0);
        check("reset.fault_cnt", 64'(fault_cnt), 64'd0);
        check("reset.uncorr_cnt", 64'(uncorr_cnt), 64'd0);

        clear_masks();
        run_txn("add_clean", 3'd0, 32'hF5, 32'hAA, 0);
        clear_masks(); masks[1] = 32'hFFFF_FFFF;
        run_txn("add_exec2_fault", 3'd0, 32'hF5, 32'hAA, 1);
        clear_masks(); masks[0] = 32'h1; masks[1] = 32'h2; masks[2] = 32'h4;
        run_txn("add_round1_fail", 3'd0, 32'hF5, 32'hAA, 0);
        clear_masks();
        for (int i = 0; i < NM; i++) masks[i] = 32'(i + 1);
        run_txn("add_uncorrectable", 3'd0, 32'hF5, 32'hAA, 2);
        clear_masks(); masks[0] = 32'h10; masks[1] = 32'h10;
        run_txn("same_corruption", 3'd3, 32'h0F0F_0000, 32'h00F0, 0);
        clear_masks();
        run_txn("sub_overflow_hold", 3'd1, 32'h8000_0000, 32'h1, 5);

        reset_mid_txn();
        clear_masks();
        run_txn("after_reset", 3'd0, 32'hF5, 32'hAA, 0);

        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < NM; i++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r < 6)      masks[i] = '0;
                else if (r < 8) masks[i] = (r == 6) ? 32'h1 : 32'h8000_0000;
                else            masks[i] = $urandom;
            end
            run_txn("rand", 3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                    $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
